// File: rtl/ysyx_23060208_lsu.sv
// ysyx_23060208_lsu: single-outstanding load/store unit. Accepts one request
// at a time on a valid/ready port, issues it on AXI-lite style AR/R or
// AW/W/B channels, and returns one response (data, register index, error).

module ysyx_23060208_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int TIMEOUT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_is_store,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [REG_WIDTH-1:0]    req_rd,

    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [REG_WIDTH-1:0]    resp_rd,
    output logic                    resp_is_store,
    output logic [1:0]              resp_err,

    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,

    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic                    rready,

    output logic                    busy
);

    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AWW  = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    logic [2:0]            state;
    logic                  is_store_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [REG_WIDTH-1:0]  rd_q;
    logic                  aw_pend;
    logic                  w_pend;
    logic [TO_W-1:0]       to_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            err_q;

    logic                  req_accept;
    logic                  req_misaligned;
    logic                  timeout_hit;
    logic [OFF_W-1:0]      offset;
    logic [31:0]           off_bytes;
    logic [31:0]           nbytes;
    logic [31:0]           nbits;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] lane;
    logic                  lane_sign;
    logic                  lane_fill;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  aw_done;
    logic                  w_done;

    assign req_accept  = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

    assign offset    = addr_q[OFF_W-1:0];
    assign off_bytes = 32'(offset);
    assign nbytes    = 32'd1 << size_q;
    assign nbits     = 32'd8 << size_q;
    assign bus_addr  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

    // Status and handshake outputs decoded from the current state
    assign req_ready     = (state == S_IDLE);
    assign busy          = (state != S_IDLE);
    assign arvalid       = (state == S_AR);
    assign rready        = (state == S_R);
    assign awvalid       = (state == S_AWW) && aw_pend;
    assign wvalid        = (state == S_AWW) && w_pend;
    assign bready        = (state == S_B);
    assign resp_valid    = (state == S_RESP);
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;
    assign resp_rd       = rd_q;
    assign resp_is_store = is_store_q;

    // Write/read channel payloads derived from the registered request
    assign araddr = bus_addr;
    assign awaddr = bus_addr;
    assign wdata  = wdata_q << {offset, 3'b000};

    // Channel completes when it already handshook or handshakes this cycle
    assign aw_done = !aw_pend || awready;
    assign w_done  = !w_pend || wready;

    // Alignment check on the incoming request; dword is illegal on a 32-bit bus
    always_comb begin
        req_misaligned = 1'b0;
        case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = |req_addr[1:0];
            default: req_misaligned = (DATA_WIDTH == 32) ? 1'b1 : |req_addr[2:0];
        endcase
    end

    // Byte strobes: N contiguous lanes starting at the address offset
    always_comb begin
        wstrb = '0;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            wstrb[i] = (i >= off_bytes) && (i < off_bytes + nbytes);
        end
    end

    // Load lane extraction with sign or zero extension above the access size
    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    lane_sign = lane[7];
            2'd1:    lane_sign = lane[15];
            2'd2:    lane_sign = lane[31];
            default: lane_sign = lane[DATA_WIDTH-1];
        endcase
        lane_fill = lane_sign & ~unsigned_q;
        load_data = '0;
        for (int unsigned i = 0; i < DW; i++) begin
            load_data[i] = (i < nbits) ? lane[i] : lane_fill;
        end
    end

    // Transaction FSM, request capture, response payload and timeout counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            is_store_q <= 1'b0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            aw_pend    <= 1'b0;
            w_pend     <= 1'b0;
            to_cnt     <= '0;
            rdata_q    <= '0;
            err_q      <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_accept) begin
                        is_store_q <= req_is_store;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        rd_q       <= req_rd;
                        rdata_q    <= '0;
                        err_q      <= ERR_OK;
                        if (req_misaligned) begin
                            err_q <= ERR_MISALIGN;
                            state <= S_RESP;
                        end else if (req_is_store) begin
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                            state   <= S_AWW;
                        end else begin
                            state <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        to_cnt <= '0;
                        state  <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        if (rresp != 2'b00) begin
                            err_q   <= ERR_BUS;
                            rdata_q <= '0;
                        end else begin
                            rdata_q <= load_data;
                        end
                        state <= S_RESP;
                    end else if (timeout_hit) begin
                        err_q <= ERR_TIMEOUT;
                        state <= S_RESP;
                    end else if (TIMEOUT != 0) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_AWW: begin
                    if (aw_pend && awready) aw_pend <= 1'b0;
                    if (w_pend && wready)   w_pend  <= 1'b0;
                    if (aw_done && w_done) begin
                        to_cnt <= '0;
                        state  <= S_B;
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        err_q <= (bresp != 2'b00) ? ERR_BUS : ERR_OK;
                        state <= S_RESP;
                    end else if (timeout_hit) begin
                        err_q <= ERR_TIMEOUT;
                        state <= S_RESP;
                    end else if (TIMEOUT != 0) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// tb_ysyx_23060208_lsu: randomized and directed checks of the LSU against an
// arithmetic reference model (32-bit bus with timeout, plus a 64-bit bus).

module tb_ysyx_23060208_lsu;

    localparam int DW    = 32;
    localparam int TO    = 8;
    localparam int NEVER = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- 32-bit DUT ----------------
    logic          req_valid = 0, req_ready, req_is_store = 0, req_unsigned = 0;
    logic [1:0]    req_size = 0;
    logic [31:0]   req_addr = 0, req_wdata = 0;
    logic [4:0]    req_rd = 0;
    logic          resp_valid, resp_ready = 0, resp_is_store;
    logic [31:0]   resp_rdata;
    logic [4:0]    resp_rd;
    logic [1:0]    resp_err;
    logic [31:0]   awaddr, araddr, wdata;
    logic          awvalid, awready = 0, wvalid, wready = 0;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = 0, rresp = 0;
    logic          bvalid = 0, bready, arvalid, arready = 0;
    logic [31:0]   rdata = 0;
    logic          rvalid = 0, rready, busy;

    ysyx_23060208_lsu #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(32), .REG_WIDTH(5), .TIMEOUT(TO)
    ) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_is_store(resp_is_store), .resp_err(resp_err),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .busy(busy)
    );

    // ---------------- 64-bit DUT, zero-wait slave ----------------
    logic          req_valid_w = 0, req_ready_w, req_is_store_w = 0, req_unsigned_w = 0;
    logic [1:0]    req_size_w = 0;
    logic [31:0]   req_addr_w = 0;
    logic [63:0]   req_wdata_w = 0;
    logic [4:0]    req_rd_w = 0;
    logic          resp_valid_w, resp_ready_w = 0, resp_is_store_w;
    logic [63:0]   resp_rdata_w;
    logic [4:0]    resp_rd_w;
    logic [1:0]    resp_err_w;
    logic [31:0]   awaddr_w, araddr_w;
    logic [63:0]   wdata_w, rdata_w = 0;
    logic [7:0]    wstrb_w;
    logic          awvalid_w, wvalid_w, bvalid_w, bready_w, arvalid_w, rvalid_w, rready_w, busy_w;

    assign bvalid_w = bready_w;
    assign rvalid_w = rready_w;

    ysyx_23060208_lsu #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .REG_WIDTH(5), .TIMEOUT(0)
    ) u_dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_w), .req_ready(req_ready_w), .req_is_store(req_is_store_w),
        .req_size(req_size_w), .req_unsigned(req_unsigned_w), .req_addr(req_addr_w),
        .req_wdata(req_wdata_w), .req_rd(req_rd_w),
        .resp_valid(resp_valid_w), .resp_ready(resp_ready_w), .resp_rdata(resp_rdata_w),
        .resp_rd(resp_rd_w), .resp_is_store(resp_is_store_w), .resp_err(resp_err_w),
        .awaddr(awaddr_w), .awvalid(awvalid_w), .awready(1'b1),
        .wdata(wdata_w), .wstrb(wstrb_w), .wvalid(wvalid_w), .wready(1'b1),
        .bresp(2'b00), .bvalid(bvalid_w), .bready(bready_w),
        .araddr(araddr_w), .arvalid(arvalid_w), .arready(1'b1),
        .rdata(rdata_w), .rresp(2'b00), .rvalid(rvalid_w), .rready(rready_w),
        .busy(busy_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction on the 32-bit DUT: master drives the request,
    // the bench plays the slave with the given delays, and the response is
    // compared with values computed from the access rules.
    task automatic run_txn(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                           input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                           input int b_dly, input logic [31:0] rword, input logic [1:0] rr,
                           input logic [1:0] br, input int hold, input bit rst_in_b);
        int nb, off, exp_lat, cyc, r_entry, bad, bad_hold, stray;
        int ar_w, r_w, aw_w, w_w, b_w, ar_hs, r_hs, aw_hs, w_hs, b_hs;
        bit mis, go;
        logic [63:0] lane, modv;
        logic [31:0] exp_rdata, exp_addr, exp_wdata, tmp;
        logic [3:0]  exp_wstrb;
        logic [1:0]  exp_err;
        logic        p_ar, p_arr, p_aw, p_awr, p_w, p_wr;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;

        nb  = 1 << sz;
        off = int'(addr % 4);
        mis = (sz == 2'd3) || (addr % nb != 0);
        exp_addr  = addr & ~32'h3;
        exp_wdata = wd << (8 * off);
        tmp       = ((32'd1 << nb) - 32'd1) << off;
        exp_wstrb = tmp[3:0];
        exp_rdata = 32'd0;
        exp_err   = 2'b00;
        go        = !mis;
        if (mis) begin
            exp_err = 2'b01;
            exp_lat = 1;
        end else if (!st) begin
            if (r_dly == NEVER) begin
                exp_err = 2'b11;
                exp_lat = 2 + ar_dly + TO;
            end else begin
                exp_lat = 3 + ar_dly + r_dly;
                if (rr != 2'b00) begin
                    exp_err = 2'b10;
                end else begin
                    modv = 64'd1 << (8 * nb);
                    lane = ({32'd0, rword} >> (8 * off)) % modv;
                    if (!uns && lane >= modv / 2) lane = lane - modv;
                    exp_rdata = lane[31:0];
                end
            end
        end else begin
            exp_lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            exp_err = (br != 2'b00) ? 2'b10 : 2'b00;
        end

        req_valid = 1; req_is_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_rd = rd;
        check("req_ready_before", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0; req_is_store = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);

        cyc = 1; r_entry = -1; bad = 0;
        ar_w = 0; r_w = 0; aw_w = 0; w_w = 0; b_w = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        p_ar = 0; p_arr = 0; p_aw = 0; p_awr = 0; p_w = 0; p_wr = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
        while (cyc < 60) begin
            if (p_ar && !p_arr && (!arvalid || araddr !== p_araddr)) bad++;
            if (p_aw && !p_awr && (!awvalid || awaddr !== p_awaddr)) bad++;
            if (p_w && !p_wr && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) bad++;
            if (arvalid && (st || mis)) bad++;
            if ((awvalid || wvalid) && (!st || mis)) bad++;
            if (resp_valid) break;

            if (rst_in_b && bready && b_w == 2) begin
                rst = 0; bvalid = 0;
                @(posedge clk); #1;
                check("rst_bready", bready, 0);
                check("rst_busy", busy, 0);
                check("rst_resp_valid", resp_valid, 0);
                check("rst_awvalid", awvalid, 0);
                rst = 1;
                check("rst_release_ready", req_ready, 1);
                @(posedge clk); #1;
                check("rst_no_resp", resp_valid, 0);
                check("rst_idle_ready", req_ready, 1);
                return;
            end

            arready = arvalid && (ar_w >= ar_dly);
            if (arvalid) begin
                ar_w++;
                if (arready) begin ar_hs++; check("araddr", araddr, exp_addr); end
            end
            if (rready && r_entry < 0) r_entry = cyc;
            rvalid = 0; rdata = $urandom; rresp = 2'($urandom);
            if (rready) begin
                if (r_dly != NEVER && r_w >= r_dly) begin
                    rvalid = 1; rdata = rword; rresp = rr; r_hs++;
                end
                r_w++;
            end
            awready = awvalid && (aw_w >= aw_dly);
            if (awvalid) begin
                aw_w++;
                if (awready) begin aw_hs++; check("awaddr", awaddr, exp_addr); end
            end
            wready = wvalid && (w_w >= w_dly);
            if (wvalid) begin
                w_w++;
                if (wready) begin
                    w_hs++;
                    check("wdata", wdata, exp_wdata);
                    check("wstrb", wstrb, exp_wstrb);
                end
            end
            bvalid = 0; bresp = 2'($urandom);
            if (bready) begin
                if (b_dly != NEVER && b_w >= b_dly) begin
                    bvalid = 1; bresp = br; b_hs++;
                end
                b_w++;
            end
            p_ar = arvalid; p_arr = arready; p_araddr = araddr;
            p_aw = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_w = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
            @(posedge clk); #1;
            cyc++;
        end
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

        check("resp_valid", resp_valid, 1);
        if (!resp_valid) return;
        check("latency", 64'(cyc), 64'(exp_lat));
        if (exp_err == 2'b11) check("timeout_after_R", 64'(cyc - r_entry), 64'(TO));
        check("resp_err", resp_err, exp_err);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_rd", resp_rd, rd);
        check("resp_is_store", resp_is_store, st);
        check("ar_hs", 64'(ar_hs), 64'(go && !st));
        check("r_hs", 64'(r_hs), 64'(go && !st && r_dly != NEVER));
        check("aw_hs", 64'(aw_hs), 64'(go && st));
        check("w_hs", 64'(w_hs), 64'(go && st));
        check("b_hs", 64'(b_hs), 64'(go && st));
        check("protocol", 64'(bad), 0);

        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err ||
                resp_rd !== rd) bad_hold++;
        end
        check("resp_hold", 64'(bad_hold), 0);
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        check("resp_drop", resp_valid, 0);
        check("idle_ready", req_ready, 1);

        if (exp_err == 2'b11) begin
            stray = 0;
            rvalid = 1; rdata = rword; rresp = 2'b00;
            for (int s = 0; s < 3; s++) begin
                @(posedge clk); #1;
                if (rready !== 1'b0 || bready !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0) stray++;
            end
            rvalid = 0;
            check("late_rvalid_ignored", 64'(stray), 0);
        end
    endtask

    // Zero-wait transaction on the 64-bit DUT with caller-supplied expectations
    task automatic run64(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rword,
                         input logic [31:0] exp_addr, input logic [63:0] exp_rdata,
                         input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
        int cyc;
        req_valid_w = 1; req_is_store_w = st; req_size_w = sz; req_unsigned_w = uns;
        req_addr_w = addr; req_wdata_w = wd; req_rd_w = 5'd9; rdata_w = rword;
        @(posedge clk); #1;
        req_valid_w = 0;
        cyc = 1;
        while (cyc < 20 && !resp_valid_w) begin
            if (arvalid_w) check("w64_araddr", araddr_w, exp_addr);
            if (awvalid_w) begin
                check("w64_awaddr", awaddr_w, exp_addr);
                check("w64_wdata", wdata_w, exp_wdata);
                check("w64_wstrb", wstrb_w, exp_wstrb);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("w64_resp_valid", resp_valid_w, 1);
        check("w64_latency", 64'(cyc), 3);
        check("w64_rdata", resp_rdata_w, exp_rdata);
        check("w64_err", resp_err_w, 2'b00);
        resp_ready_w = 1;
        @(posedge clk); #1;
        resp_ready_w = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        st, uns;
        logic [1:0]  sz, rr, br;
        logic [31:0] addr;
        int          r_dly;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        rst = 1;
        @(posedge clk); #1;
        check("post_rst_ready", req_ready, 1);

        // lb sign-extending the top byte
        run_txn(0, 0, 0, 32'h8000_0003, 0, 5'd1, 0, 0, 0, 0, 0, 32'h8012_3456, 0, 0, 0, 0);
        // sh to upper half, AW late, W immediate
        run_txn(1, 1, 0, 32'h8000_0002, 32'h0000_BEEF, 5'd2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        // misaligned lw
        run_txn(0, 2, 0, 32'h8000_0002, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // lhu with bus error, response held for 5 cycles
        run_txn(0, 1, 1, 32'h8000_0000, 0, 5'd4, 1, 2, 0, 0, 0, 32'h1234_5678, 2'b10, 0, 5, 0);
        // lw with no rvalid: timeout then stray rvalid
        run_txn(0, 2, 0, 32'h8000_0004, 0, 5'd5, 0, NEVER, 0, 0, 0, 32'hCAFE_F00D, 0, 0, 0, 0);
        // zero-wait sw, and W late with AW immediate
        run_txn(1, 2, 0, 32'h8000_0008, 32'hDEAD_BEEF, 5'd6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_txn(1, 0, 0, 32'h8000_0005, 32'h0000_00A5, 5'd7, 0, 0, 0, 2, 1, 0, 0, 2'b11, 1, 0);
        // dword on a 32-bit bus is always misaligned
        run_txn(0, 3, 0, 32'h8000_0000, 0, 5'd8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // reset while waiting in B
        run_txn(1, 2, 0, 32'h8000_0010, 32'h1111_2222, 5'd9, 0, 0, 0, 0, NEVER, 0, 0, 0, 0, 1);
        // clean transaction right after the abort
        run_txn(0, 1, 0, 32'h8000_0006, 0, 5'd10, 0, 0, 0, 0, 0, 32'h9ABC_0000, 0, 0, 0, 0);

        for (int k = 0; k < 150; k++) begin
            st   = 1'($urandom);
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom);
            addr = 32'h8000_0000 | ($urandom & 32'hFF);
            if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << sz) - 32'd1);
            r_dly = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 4));
            rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(st, sz, uns, addr, $urandom, 5'($urandom), int'($urandom_range(0, 4)), r_dly,
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    $urandom, rr, br, int'($urandom_range(0, 2)), 0);
        end

        run64(0, 3, 0, 32'h8000_0008, 0, 64'h0123_4567_89AB_CDEF,
              32'h8000_0008, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00);
        run64(0, 2, 0, 32'h8000_000C, 0, 64'h89AB_CDEF_0000_0000,
              32'h8000_0008, 64'hFFFF_FFFF_89AB_CDEF, 64'h0, 8'h00);
        run64(0, 2, 1, 32'h8000_000C, 0, 64'h89AB_CDEF_0000_0000,
              32'h8000_0008, 64'h0000_0000_89AB_CDEF, 64'h0, 8'h00);
        run64(1, 2, 0, 32'h8000_0004, 64'h0000_0000_1122_3344, 0,
              32'h8000_0000, 64'h0, 64'h1122_3344_0000_0000, 8'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_lsu.md
YSYX_23060208_LSU -- requirements
Module: ysyx_23060208_lsu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bus data width; legal values are 32 or 64.
REQ-002 Parameter ADDR_WIDTH, default 32: address width.
REQ-003 Parameter REG_WIDTH, default 5: destination register index width.
REQ-004 Parameter TIMEOUT, default 0: maximum cycles to wait for rvalid/bvalid; 0 disables the timeout.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-007 req_valid in 1; req_ready out 1: upstream request handshake.
REQ-008 req_is_store in 1; req_size in 2 (0 byte, 1 half, 2 word, 3 dword); req_unsigned in 1.
REQ-009 req_addr in ADDR_WIDTH; req_wdata in DATA_WIDTH (store data, LSB-justified); req_rd in REG_WIDTH.
REQ-010 resp_valid out 1; resp_ready in 1; resp_rdata out DATA_WIDTH; resp_rd out REG_WIDTH; resp_is_store out 1; resp_err out 2 (00 ok, 01 misaligned, 10 bus error, 11 timeout).
REQ-011 awaddr out ADDR_WIDTH; awvalid out 1; awready in 1.
REQ-012 wdata out DATA_WIDTH; wstrb out DATA_WIDTH/8; wvalid out 1; wready in 1.
REQ-013 bresp in 2; bvalid in 1; bready out 1.
REQ-014 araddr out ADDR_WIDTH; arvalid out 1; arready in 1.
REQ-015 rdata in DATA_WIDTH; rresp in 2; rvalid in 1; rready out 1.
REQ-016 busy out 1: high in every state except IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, AR, R, AWW, B, RESP.
REQ-018 req_ready SHALL equal (state==IDLE); a request is accepted on req_valid&&req_ready, and all req_* fields are registered at that edge.
REQ-019 Size byte count N = 1<<req_size; size 3 with DATA_WIDTH=32 SHALL be treated as misaligned.
REQ-020 If addr mod N != 0, IDLE SHALL go to RESP with err=01, and no AR/AW/W valid SHALL be asserted.
REQ-021 An aligned load SHALL go IDLE->AR; arvalid=1 in AR, araddr = addr with its low log2(DATA_WIDTH/8) bits cleared; AR->R on arready.
REQ-022 In R, rready=1; on rvalid the block SHALL capture rdata/rresp and go to RESP.
REQ-023 Load data: lane = rdata >> (8*offset), where offset = the address low bits; the lane is truncated to N bytes and then sign-extended (req_unsigned=0) or zero-extended (req_unsigned=1) to DATA_WIDTH.
REQ-024 rresp != 0 SHALL give err=10 and resp_rdata=0.
REQ-025 An aligned store SHALL go IDLE->AWW; awvalid and wvalid are both set on entry; each drops independently on its own handshake; AWW->B once both have handshaked (same-cycle or in either order).
REQ-026 wdata = req_wdata << (8*offset); wstrb = ((1<<N)-1) << offset; awaddr is aligned as araddr.
REQ-027 In B, bready=1; on bvalid go to RESP; bresp != 0 SHALL give err=10; stores return resp_rdata=0.
REQ-028 TIMEOUT>0: a counter SHALL clear on entry to R/B and increment each cycle while waiting; reaching TIMEOUT SHALL go to RESP with err=11, and a later stray rvalid/bvalid in IDLE SHALL be ignored (rready=bready=0).
REQ-029 In RESP, resp_valid=1 with stable payload until resp_ready; then go to IDLE; the next request can be accepted in the following cycle.
REQ-030 A valid, once asserted, SHALL NOT drop before its handshake, and its payload SHALL stay stable.
REQ-031 Minimum latency with zero-wait slave: load accepted at cycle 0, arvalid at cycle 1, R at 2, resp_valid at 3; store: resp_valid at 3.
REQ-032 At most one transaction SHALL be in flight; no new request is accepted before its response handshake.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE; arvalid, awvalid, wvalid, rready, bready, resp_valid, busy = 0; resp_err=0; resp_rdata=0; timeout counter=0.
REQ-034 Reset applied mid-transaction SHALL abort it: all valid/ready outputs are 0 the cycle after, with no response issued.
REQ-035 req_ready SHALL be 1 in the first cycle after rst returns to 1.

Verification
REQ-036 lb, addr 0x8000_0003, DW=32, rdata 0x80xx_xxxx -> araddr 0x8000_0000, resp_rdata 0xFFFF_FF80, err 00.
REQ-037 sh, addr 0x8000_0002, data 0x0000_BEEF -> wdata 0xBEEF_0000, wstrb 4'b1100; awready delayed 3 cycles and wready immediate -> exactly one handshake each, single response.
REQ-038 lw at 0x8000_0002 -> err 01 at cycle 1, no arvalid ever seen.
REQ-039 lhu with rresp=2'b10 -> err 10, resp_rdata 0; resp_ready held low 5 cycles -> payload stable throughout.
REQ-040 TIMEOUT=8, load, rvalid never asserted -> err 11 eight cycles after entering R; a late rvalid is ignored.
REQ-041 rst=0 asserted while in B -> bready=0 next cycle, state IDLE, no resp_valid; DW=64 ld at 0x...8 -> resp_rdata = full rdata.
